// File: rtl/date_seg_scan.sv
// -----------------------------------------------------------------------------
// date_seg_scan
//   Multiplexed 4-digit 7-segment driver for the date counter chain.
//   Shows one of two pages: MM.DD (page 0) or YYYY (page 1). Digits selected
//   by blink_mask are blanked during the "off" half of a slow blink period,
//   for use in date-setting mode.
//
// Ports
//   clk         in   1   system clock, posedge
//   rst         in   1   asynchronous, active-low reset
//   date_bcd    in   32  {Y3,Y2,Y1,Y0,M1,M0,D1,D0}, 4-bit BCD each
//   page        in   1   0 = MM.DD, 1 = YYYY (taken at frame boundaries)
//   blink_mask  in   4   bit i = 1 -> digit i blinks; digit 3 = leftmost
//   an          out  4   digit enables, active-low, one-hot-low when lit
//   seg         out  8   {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick  out  1   one-cycle pulse after the scan index wraps 3 -> 0
// -----------------------------------------------------------------------------
module date_seg_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] date_bcd,
  input  logic        page,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [1:0]         idx;
  logic               blink_ph;
  logic               page_q;

  logic               tick;
  logic               wrap;
  logic [1:0]         idx_nxt;
  logic               page_nxt;
  logic [4:0]         nib_base;
  logic [3:0]         nib;
  logic               dp_n;
  logic [3:0]         an_nxt;
  logic [7:0]         seg_nxt;

  // Active-low {g,f,e,d,c,b,a}; anything that is not a decimal digit shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  assign tick = (scan_cnt == SCAN_LAST);
  assign wrap = tick && (idx == 2'd3);

  // Output registers are loaded from the slot being entered, so everything
  // below is computed from the post-edge index and page.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    idx_nxt  = idx + 2'd1;
    page_nxt = wrap ? page : page_q;
    // {page, idx} picks nibble 0..7 of date_bcd: day/month on page 0, year on page 1.
    nib_base = {page_nxt, idx_nxt, 2'b00};
    nib      = date_bcd[nib_base +: 4];
    dp_n     = !(!page_nxt && (idx_nxt == 2'd2));
    seg_nxt  = {dp_n, decode(nib)};
    an_nxt   = ~(4'b0001 << idx_nxt);
    // Blanking only gates the digit enable; seg keeps the decoded value.
    if (blink_ph && blink_mask[idx_nxt]) begin
      an_nxt = 4'b1111;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt   <= '0;
      blink_cnt  <= '0;
      idx        <= 2'd0;
      blink_ph   <= 1'b0;
      page_q     <= 1'b0;
      an         <= 4'b1111;
      seg        <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + SCAN_W'(1);

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end

      frame_tick <= wrap;

      if (tick) begin
        idx    <= idx_nxt;
        page_q <= page_nxt;
        an     <= an_nxt;
        seg    <= seg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_date_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_date_seg_scan
//   Directed bench for date_seg_scan with SCAN_DIV = 4, BLINK_DIV = 64.
//   A slot model pushes the expected post-tick outputs into a scoreboard
//   queue before each slot is run; the entry is popped and compared once the
//   tick edge has happened. Between ticks the outputs must hold and
//   frame_tick must stay low.
// -----------------------------------------------------------------------------
module tb_date_seg_scan;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] date_bcd;
  logic        page;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  date_seg_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .date_bcd   (date_bcd),
    .page       (page),
    .blink_mask (blink_mask),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       ft;
  } exp_t;

  exp_t sb[$];
  exp_t prev;

  int   checks   = 0;
  int   failures = 0;
  int   n_edges  = 0;   // clock edges since reset release
  int   m_idx    = 0;   // model scan index
  logic m_page   = 1'b0; // model latched page
  int   blanked  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;  4'd1: seg7 = 7'h79;  4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;  4'd4: seg7 = 7'h19;  4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;  4'd7: seg7 = 7'h78;  4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;  default: seg7 = 7'h3F;
    endcase
  endfunction

  // Assert reset, check the asynchronous clear, then release just after an edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_an",  an,         32'hF);
    check("rst_seg", seg,        32'hFF);
    check("rst_ft",  frame_tick, 32'h0);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    n_edges = 0;
    m_idx   = 0;
    m_page  = 1'b0;
    prev    = '{an: 4'hF, seg: 8'hFF, ft: 1'b0};
  endtask

  // Run one scan slot: predict the values loaded at its closing tick edge,
  // then step through the slot checking hold behaviour and the tick result.
  task automatic do_slot();
    exp_t       e;
    exp_t       got;
    int         ni;
    int         tick_n;
    logic       ph;
    logic [3:0] nib;
    ni     = (m_idx + 1) % 4;
    tick_n = n_edges + SCAN_DIV;
    ph     = (((tick_n - 1) / BLINK_DIV) % 2) == 1;
    if (ni == 0) m_page = page;
    nib    = date_bcd[(m_page ? 16 : 0) + ni * 4 +: 4];
    e.seg  = {(!m_page && ni == 2) ? 1'b0 : 1'b1, seg7(nib)};
    e.an   = (ph && blink_mask[ni]) ? 4'hF : ~(4'b0001 << ni);
    e.ft   = (ni == 0);
    sb.push_back(e);
    for (int k = 1; k <= SCAN_DIV; k++) begin
      @(posedge clk);
      #1;
      n_edges++;
      if (k < SCAN_DIV) begin
        check("hold_an",  an,         {28'h0, prev.an});
        check("hold_seg", seg,        {24'h0, prev.seg});
        check("ft_idle",  frame_tick, 32'h0);
      end
    end
    got = sb.pop_front();
    check("slot_an",  an,         {28'h0, got.an});
    check("slot_seg", seg,        {24'h0, got.seg});
    check("slot_ft",  frame_tick, {31'h0, got.ft});
    if (got.an == 4'hF) blanked++;
    prev  = got;
    m_idx = ni;
  endtask

  logic [3:0] tab_an  [4];
  logic [7:0] tab_seg [4];

  initial begin
    date_bcd   = 32'h2024_0417;
    page       = 1'b0;
    blink_mask = 4'b0000;
    #12;

    // Basic MM.DD scan: slots idx 1,2,3,0 with literal expectations.
    tab_an  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    tab_seg = '{8'hF9,   8'h19,   8'hC0,   8'hF8};
    do_reset();
    for (int s = 0; s < 4; s++) begin
      do_slot();
      check("s1_an",  an,  {28'h0, tab_an[s]});
      check("s1_seg", seg, {24'h0, tab_seg[s]});
    end

    // A second full frame: one frame_tick per 16 clocks.
    for (int s = 0; s < 4; s++) do_slot();

    // Page change mid-frame must not tear the frame in progress.
    do_slot();                 // idx 1
    page = 1'b1;
    do_slot();                 // idx 2, still MM.DD with dp lit
    check("p3_keep_dp", seg, 32'h19);
    do_slot();                 // idx 3, still MM.DD
    check("p3_keep_m1", seg, 32'hC0);
    tab_seg = '{8'h99, 8'hA4, 8'hC0, 8'hA4}; // Y0=4, Y1=2, Y2=0, Y3=2
    for (int s = 0; s < 4; s++) begin
      do_slot();
      check("p3_year", seg, {24'h0, tab_seg[s]});
    end

    // Non-decimal nibble shows a dash; back on the MM.DD page.
    page     = 1'b0;
    date_bcd = 32'h2024_041B;
    for (int s = 0; s < 8; s++) begin
      do_slot();
      if (m_idx == 0) check("dash", seg, 32'hBF);
    end

    // Blink the leftmost digit over 200+ clocks.
    blink_mask = 4'b1000;
    blanked    = 0;
    for (int s = 0; s < 52; s++) do_slot();
    assert (blanked > 0) else begin
      failures++;
      $error("FAIL blink_seen observed=%0d expected=nonzero", blanked);
    end
    checks++;
    blink_mask = 4'b0000;

    // Reset in the middle of a slot, while frame_tick is high.
    while (m_idx != 0) do_slot();
    check("pre_rst_ft", frame_tick, 32'h1);
    do_reset();
    date_bcd = 32'h2024_0417;
    tab_seg  = '{8'hF9, 8'h19, 8'hC0, 8'hF8};
    for (int s = 0; s < 4; s++) begin
      do_slot();
      check("r6_an",  an,  {28'h0, tab_an[s]});
      check("r6_seg", seg, {24'h0, tab_seg[s]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
